// File: rtl/ser_pkg.sv
// ser_pkg: shared constants, payload layout and FSM encoding for the serial link
package ser_pkg;
   localparam int CLK_PER_BIT = 4;
   localparam int FRAME_SYMS  = 256;
   localparam logic [9:0] K28_5_RDN  = 10'b0011111010;
   localparam logic [9:0] K28_5_RDP  = 10'b1100000101;
   localparam logic [7:0] K28_5_BYTE = 8'hBC;
   localparam int POS_ISPRO    = 7;
   localparam int POS_ISMASTER = 6;
   localparam int POS_RAWPLS   = 5;
   localparam int POS_P1       = 4;
   localparam int POS_OPT_HI   = 3;
   localparam int POS_OPT_LO   = 1;
   localparam int POS_P2       = 0;
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_COMMA = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   // Each nibble carries odd parity so a stuck nibble is detectable at the slave
   function automatic logic [7:0] make_payload(input logic is_pro, is_master, raw_pls,
                                               input logic [2:0] option);
      logic [7:0] p;
      p = '0;
      p[POS_ISPRO] = is_pro;
      p[POS_ISMASTER] = is_master;
      p[POS_RAWPLS] = raw_pls;
      p[POS_P1] = ~^{is_pro, is_master, raw_pls};
      p[POS_OPT_HI:POS_OPT_LO] = option;
      p[POS_P2] = ~^option;
      return p;
   endfunction
endpackage

// File: rtl/encode_8b10b.sv
// encode_8b10b: combinational 8b10b encoder, dataout = {abcdei, fghj} with a in bit 9
module encode_8b10b (
   input  logic [7:0] datain,
   input  logic       kin,
   input  logic       dispin,
   output logic [9:0] dataout,
   output logic       dispout
);
   // 5b/6b and 3b/4b codes in their RD- form
   localparam logic [5:0] T6 [32] = '{
      6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
      6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
      6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
      6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
   localparam logic [3:0] T4 [8] = '{
      4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
   logic [4:0] x;
   logic [2:0] y;
   logic [5:0] c6, o6;
   logic [3:0] c4, p4, o4;
   logic       k28, u6, u4, rdm, a7;
   assign x = datain[4:0];
   assign y = datain[7:5];
   assign k28 = kin && x == 5'd28;
   assign c6 = k28 ? 6'b001111 : T6[x];
   assign u6 = $countones(c6) != 3;
   assign o6 = dispin && (u6 || x == 5'd7) ? ~c6 : c6;
   assign rdm = dispin ^ u6;
   // Alternate x.7 avoids a run of five equal bits across the sub-block seam
   assign a7 = y == 3'd7 && (kin || (!rdm && (x == 5'd17 || x == 5'd18 || x == 5'd20))
                                 || (rdm && (x == 5'd11 || x == 5'd13 || x == 5'd14)));
   assign c4 = a7 ? 4'b0111 : T4[y];
   assign u4 = $countones(c4) != 2;
   assign p4 = u4 || y == 3'd3 ? ~c4 : c4;
   assign o4 = rdm ? p4 : (k28 ? ~p4 : c4);
   assign dataout = {o6, o4};
   assign dispout = rdm ^ u4;
endmodule

// File: rtl/serial_tx_master.sv
// serial_tx_master: frame builder, 8b10b encoder and MSB-first serializer for the SFP link
module serial_tx_master #(
   parameter int CLK_PER_BIT = ser_pkg::CLK_PER_BIT,
   parameter int FRAME_SYMS  = ser_pkg::FRAME_SYMS
) (
   input  logic       i_clk,
   input  logic       i_res_n,
   input  logic       i_tx_en,
   input  logic       i_IsPro,
   input  logic       i_IsMaster,
   input  logic       i_RawPls,
   input  logic [2:0] i_Option,
   output logic       o_SerialData,
   output logic       o_tx_dis,
   output logic       o_sym_load,
   output logic       o_tx_led
);
   import ser_pkg::*;
   localparam int DW = CLK_PER_BIT > 1 ? $clog2(CLK_PER_BIT) : 1;
   localparam int SW = FRAME_SYMS > 1 ? $clog2(FRAME_SYMS) : 1;
   logic [1:0]    state;
   logic [DW-1:0] div;
   logic [3:0]    bitc;
   logic [SW-1:0] symc, symc_nxt;
   logic [9:0]    shreg, code;
   logic          rd, code_rd, bit_end, sym_end, comma, load;
   assign bit_end = div == DW'(CLK_PER_BIT - 1);
   assign sym_end = state != ST_IDLE && bit_end && bitc == 4'd9;
   assign symc_nxt = state == ST_IDLE || symc == SW'(FRAME_SYMS - 1) ? '0 : symc + 1'b1;
   assign comma = symc_nxt == '0;
   assign load = state == ST_IDLE ? i_tx_en : sym_end && i_tx_en;
   encode_8b10b u_enc (
      .datain (comma ? K28_5_BYTE : make_payload(i_IsPro, i_IsMaster, i_RawPls, i_Option)),
      .kin    (comma),
      .dispin (rd),
      .dataout(code),
      .dispout(code_rd)
   );
   // The line register always holds shreg[9], so it is updated from the next shreg value
   always_ff @(posedge i_clk or negedge i_res_n)
      if (!i_res_n) begin
         state <= ST_IDLE;
         div <= '0;
         bitc <= '0;
         symc <= '0;
         shreg <= '0;
         rd <= 1'b0;
         o_SerialData <= 1'b0;
         o_tx_dis <= 1'b1;
         o_sym_load <= 1'b0;
         o_tx_led <= 1'b0;
      end else begin
         o_sym_load <= load;
         if (load) begin
            state <= comma ? ST_COMMA : ST_DATA;
            symc <= symc_nxt;
            div <= '0;
            bitc <= '0;
            shreg <= code;
            o_SerialData <= code[9];
            rd <= code_rd;
            o_tx_dis <= 1'b0;
            if (!comma) o_tx_led <= i_RawPls;
         end else if (sym_end || state == ST_IDLE) begin
            state <= ST_IDLE;
            symc <= '0;
            div <= '0;
            bitc <= '0;
            shreg <= '0;
            rd <= 1'b0;
            o_SerialData <= 1'b0;
            o_tx_dis <= 1'b1;
            o_tx_led <= 1'b0;
         end else if (bit_end) begin
            div <= '0;
            bitc <= bitc + 1'b1;
            shreg <= {shreg[8:0], 1'b0};
            o_SerialData <= shreg[8];
         end else begin
            div <= div + 1'b1;
         end
      end
endmodule

// File: tb/tb_serial_tx_master.sv
// tb_serial_tx_master: scoreboard bench, expected 10-bit symbols queued by stimulus, checked by a line monitor
module tb_serial_tx_master;
   logic       clk = 1'b0, res_n, tx_en, is_pro, is_master, raw_pls;
   logic [2:0] opt;
   logic       ser, tx_dis, sym_load, tx_led;
   int         n_cmp = 0, n_err = 0;
   int         m_sym = 0;
   logic       m_rd = 1'b0;
   logic [9:0] sq [$];

   serial_tx_master dut (
      .i_clk(clk), .i_res_n(res_n), .i_tx_en(tx_en), .i_IsPro(is_pro), .i_IsMaster(is_master),
      .i_RawPls(raw_pls), .i_Option(opt), .o_SerialData(ser), .o_tx_dis(tx_dis),
      .o_sym_load(sym_load), .o_tx_led(tx_led));

   always #5 clk = ~clk;

   // Hand-derived codewords for the symbols this bench sends
   function automatic logic [9:0] ref_sym(input logic [7:0] b, input logic k, input logic rdi,
                                          output logic rdo);
      rdo = ~rdi;
      if (k) return rdi ? 10'b1100000101 : 10'b0011111010;
      case (b)
         8'h11: return rdi ? 10'b1000110100 : 10'b1000111011;
         8'h21: return rdi ? 10'b1000101001 : 10'b0111011001;
         8'hB4: begin rdo = rdi; return 10'b0010111010; end
         default: begin rdo = rdi; return 10'b0; end
      endcase
   endfunction

   task automatic chk(input string nm, input logic [9:0] got, input logic [9:0] req);
      n_cmp++;
      if (got !== req) begin
         n_err++;
         $display("FAIL %s got=%0h required=%0h", nm, got, req);
      end
   endtask

   task automatic push_sym();
      logic [7:0] b;
      logic [9:0] v;
      logic r;
      b = {is_pro, is_master, raw_pls, ~^{is_pro, is_master, raw_pls}, opt, ~^opt};
      v = ref_sym(b, m_sym == 0, m_rd, r);
      sq.push_back(v);
      m_rd = r;
      m_sym = m_sym == 255 ? 0 : m_sym + 1;
   endtask

   task automatic run_sym();
      push_sym();
      repeat (40) @(negedge clk);
   endtask

   initial begin
      logic [39:0] got, req;
      logic [9:0] s;
      logic aborted;
      int n = 0;
      forever begin
         @(negedge clk);
         if (sym_load) begin
            if (sq.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_symbol #%0d got=load required=none", n);
            end else begin
               s = sq.pop_front();
               aborted = 1'b0;
               got = '0;
               for (int k = 0; k < 40; k++) begin
                  if (k > 0) @(negedge clk);
                  if (!res_n) begin
                     aborted = 1'b1;
                     break;
                  end
                  got[39-k] = ser;
               end
               if (!aborted) begin
                  for (int i = 0; i < 10; i++) req[39-4*i -: 4] = {4{s[9-i]}};
                  n_cmp++;
                  if (got !== req) begin
                     n_err++;
                     $display("FAIL symbol #%0d got=%h required=%h (code %b)", n, got, req, s);
                  end
               end
            end
            n++;
         end
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog got=timeout required=finish");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      res_n = 1'b0; tx_en = 1'b1; is_pro = 1'b0; is_master = 1'b0; raw_pls = 1'b0; opt = 3'b000;
      repeat (3) @(negedge clk);
      chk("reset_ser", ser, 0);
      chk("reset_tx_dis", tx_dis, 1);
      chk("reset_sym_load", sym_load, 0);
      chk("reset_led", tx_led, 0);
      res_n = 1'b1;
      repeat (3) run_sym();
      chk("tx_dis_active", tx_dis, 0);
      chk("led_zero", tx_led, 0);
      is_pro = 1'b1; raw_pls = 1'b1; opt = 3'b010;
      repeat (800) run_sym();
      chk("led_b4", tx_led, 1);
      is_pro = 1'b0; raw_pls = 1'b0; opt = 3'b000;
      repeat (2) run_sym();
      push_sym();
      repeat (17) @(negedge clk);
      raw_pls = 1'b1;
      @(negedge clk);
      chk("led_hold_mid_symbol", tx_led, 0);
      repeat (22) @(negedge clk);
      run_sym();
      chk("led_after_toggle", tx_led, 1);
      run_sym();
      while (m_sym != 100) run_sym();
      push_sym();
      repeat (20) @(negedge clk);
      tx_en = 1'b0;
      repeat (20) @(negedge clk);
      m_rd = 1'b0;
      m_sym = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("idle_tx_dis", tx_dis, 1);
         chk("idle_ser", ser, 0);
         chk("idle_sym_load", sym_load, 0);
      end
      tx_en = 1'b1;
      repeat (2) run_sym();
      push_sym();
      repeat (6) @(negedge clk);
      #2 res_n = 1'b0;
      #1;
      chk("async_reset_ser", ser, 0);
      chk("async_reset_tx_dis", tx_dis, 1);
      chk("async_reset_sym_load", sym_load, 0);
      m_rd = 1'b0;
      m_sym = 0;
      repeat (3) @(negedge clk);
      res_n = 1'b1;
      repeat (2) run_sym();
      push_sym();
      repeat (20) @(negedge clk);
      tx_en = 1'b0;
      repeat (25) @(negedge clk);
      chk("queue_drained", 10'(sq.size()), 0);
      chk("final_tx_dis", tx_dis, 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/serial_tx_master.md
Name: serial_tx_master

Overview:
- Serial frame builder, 8b10b encoder and bit serializer in the master CPLD; drives the SFP transmitter.
- Sends a K28.5 comma followed by 255 data symbols, every 256 symbols.
- Each data symbol carries IsPro, IsMaster, RawPls, Option[2:0] and two nibble-parity bits.
- Line format is exactly what the slave-side receiver locks to: 10 Mbps from a 40 MHz clock, 4 clocks per bit.

Parameters:
- CLK_PER_BIT, 4, clock cycles per serial bit (40 MHz / 10 Mbps).
- FRAME_SYMS, 256, symbols per frame including the comma; the receiver needs a comma every 2560 bits.

Ports:
- i_clk  input  1  40 MHz system clock.
- i_res_n  input  1  reset; asynchronous, active-low.
- i_tx_en  input  1  transmit enable.
- i_IsPro  input  1  payload bit 7.
- i_IsMaster  input  1  payload bit 6.
- i_RawPls  input  1  payload bit 5; interrupter pulse level.
- i_Option  input  3  payload bits 3:1.
- o_SerialData  output  1  serial line to the SFP transmitter.
- o_tx_dis  output  1  SFP TX_DISABLE, active-high.
- o_sym_load  output  1  one-cycle strobe when a symbol is loaded.
- o_tx_led  output  1  status LED; mirrors the RawPls value latched in the current data symbol.

Behaviour:
- Reset values:
  - o_SerialData=0, o_tx_dis=1, o_sym_load=0, o_tx_led=0.
  - Running disparity = RD- (0); all counters 0; state IDLE.
- Counters:
  - clk divider 0..CLK_PER_BIT-1.
  - bit counter 0..9.
  - symbol counter 0..FRAME_SYMS-1.
- States:
  - IDLE: o_tx_dis=1, o_SerialData=0, disparity held at RD-. When i_tx_en=1, go to COMMA next cycle and load the first symbol.
  - COMMA: symbol counter=0; encode K28.5 (RD- 0011111010, RD+ 1100000101).
  - DATA: symbol counter 1..255.
- Symbol boundary: the cycle where divider=CLK_PER_BIT-1 and bit=9.
  - At the boundary, the next symbol is loaded into a 10-bit shift register and o_sym_load pulses for 1 cycle.
  - Symbol counter increments and wraps 255->0 (COMMA).
- Serialization:
  - Symbol bit 9 goes out first; each bit is held exactly CLK_PER_BIT cycles; o_SerialData is registered.
  - One symbol = 40 clocks; one frame = 10240 clocks.
- Data byte:
  - {IsPro, IsMaster, RawPls, P1, Option[2:0], P2}.
  - P1 = ~^{IsPro, IsMaster, RawPls}; P2 = ~^Option. Each nibble therefore has odd parity.
  - Inputs are sampled on the load cycle only; later input changes are ignored until the next load.
  - Latency from input change to its first serial bit is at most 40 clocks, plus 40 more if the next load is a comma.
- Disparity:
  - The encoder returns dispout for each loaded symbol (data or K); the register updates on the load cycle.
- Disable:
  - i_tx_en falling is honoured at the next symbol boundary; the partial symbol always completes.
  - Then state goes to IDLE: o_tx_dis=1, line 0, disparity reset to RD-, symbol counter 0.
  - Re-enable always starts with COMMA.
- Reset mid-symbol: immediate asynchronous return to reset values; no partial-symbol completion.

Decomposition:
- Shared package (ser_pkg):
  - K28_5_RDN=10'b0011111010, K28_5_RDP=10'b1100000101.
  - CLK_PER_BIT, FRAME_SYMS.
  - Payload bit positions (7 IsPro, 6 IsMaster, 5 RawPls, 4 P1, 3:1 Option, 0 P2).
  - State encoding IDLE/COMMA/DATA.
- Sub-module: encode_8b10b, combinational.
  - Ports: datain[7:0], kin, dispin → dataout[9:0], dispout.
  - Bit ordering matches decode_8b10b, so decode(encode(x))==x.

Test Plan:
- Reset release with i_tx_en=1, all payload inputs 0 → first 10 bits 0011111010 with 4 clocks/bit; next symbol decodes to 0x11; o_tx_dis falls to 0.
- IsPro=1, IsMaster=0, RawPls=1, Option=3'b010 → every data symbol decodes to 0xB4 with no code or disparity error; o_tx_led=1.
- Run 3 frames → commas occur exactly every 2560 bits (10240 clocks); a loopback into serial_rx_slave reaches lock with o_err_cnt=0.
- Toggle i_RawPls mid-symbol (clock 17 of 40) → the change appears only in the next loaded symbol; the current symbol is unchanged.
- Drop i_tx_en at clock 20 of symbol 100 → that symbol completes; then o_tx_dis=1 and line=0. Re-enable → the first symbol is K28.5 in RD- form.
- Assert i_res_n=0 mid-bit → o_SerialData=0, o_tx_dis=1 in the same cycle (async); after release the sequence restarts with a comma.
